// File: rtl/gray_bin_conv_pipe.sv
// ============================================================================
// Module   : gray_bin_conv_pipe
// Brief    : Registered Gray<->binary converter with valid/ready handshakes
//            and a main/skid output stage. Optional macro GRAY_ADJ_CHECK_EN
//            adds a Hamming-distance-1 check on successive mode-0 inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_bin_conv_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
`ifdef GRAY_ADJ_CHECK_EN
  ,
  output logic             adj_err,
  output logic             adj_err_sticky
`endif
);

  logic [WIDTH-1:0] w_g2b;
  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_conv;
  logic             w_acc;

  logic             r_in_ready;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             r_main_mode;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_mode;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign w_g2b[i] = ^in_data[WIDTH-1:i];
  end

  assign w_b2g  = in_data ^ (in_data >> 1);
  assign w_conv = in_mode ? w_b2g : w_g2b;
  assign w_acc  = in_valid & r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready   <= 1'b1;
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_mode  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_mode  <= 1'b0;
    end else if (r_skid_valid) begin
      // in_ready is low here, so only the skid-to-main move can happen.
      if (out_ready) begin
        r_main_data  <= r_skid_data;
        r_main_mode  <= r_skid_mode;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_acc) begin
      if (!r_main_valid || out_ready) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_conv;
        r_main_mode  <= in_mode;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_conv;
        r_skid_mode  <= in_mode;
        r_in_ready   <= 1'b0;
      end
    end else if (r_main_valid && out_ready) begin
      r_main_valid <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_mode  = r_main_mode;

`ifdef GRAY_ADJ_CHECK_EN
  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_prev;
  logic             r_have_prev;
  logic             r_adj_err;
  logic             r_adj_sticky;
  logic [WIDTH-1:0] w_diff;
  logic             w_dist1;

  assign w_diff  = in_data ^ r_prev;
  // Exactly one bit set: nonzero and a power of two.
  assign w_dist1 = (w_diff != '0) && ((w_diff & (w_diff - c_one)) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= '0;
      r_have_prev  <= 1'b0;
      r_adj_err    <= 1'b0;
      r_adj_sticky <= 1'b0;
    end else begin
      r_adj_err <= 1'b0;
      if (w_acc && !in_mode) begin
        r_prev      <= in_data;
        r_have_prev <= 1'b1;
        if (r_have_prev && !w_dist1) begin
          r_adj_err    <= 1'b1;
          r_adj_sticky <= 1'b1;
        end
      end
    end
  end

  assign adj_err        = r_adj_err;
  assign adj_err_sticky = r_adj_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_bin_conv_pipe.sv
// ============================================================================
// Module   : tb_gray_bin_conv_pipe
// Brief    : Self-checking bench for gray_bin_conv_pipe (scoreboard + directed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_bin_conv_pipe;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;
`ifdef GRAY_ADJ_CHECK_EN
  logic         adj_err;
  logic         adj_err_sticky;
`endif

  int total = 0;
  int bad   = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  gray_bin_conv_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef GRAY_ADJ_CHECK_EN
    ,
    .adj_err        (adj_err),
    .adj_err_sticky (adj_err_sticky)
`endif
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic m);
    logic [W-1:0] b;
    if (m) return d ^ (d >> 1);
    b[W-1] = d[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ d[i];
    return b;
  endfunction

  // Scoreboard: handshakes are sampled mid-cycle, pop before push.
  always @(negedge clk) begin
    logic [W:0] exp;
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got %b/%h want none", out_mode, out_data);
        end else begin
          exp = sb.pop_front();
          if ({out_mode, out_data} !== exp) begin
            bad++;
            $display("FAIL sb_data: got %b/%h want %b/%h", out_mode, out_data, exp[W], exp[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back({in_mode, model(in_data, in_mode)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    out_ready = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_mode !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_vals: got v=%b d=%h m=%b r=%b want 0 0 0 1", out_valid, out_data, out_mode, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_mode0();
    out_ready = 1'b1;
    drive(1'b1, 4'b1101, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b1001 || out_mode !== 1'b0) begin
      bad++;
      $display("FAIL mode0_a: got v=%b d=%b m=%b want 1 1001 0", out_valid, out_data, out_mode);
    end
    drive(1'b1, 4'b1000, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b1111 || out_mode !== 1'b0) begin
      bad++;
      $display("FAIL mode0_b: got v=%b d=%b m=%b want 1 1111 0", out_valid, out_data, out_mode);
    end
    drive(1'b0, '0, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mode0_idle: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_mode1();
    out_ready = 1'b1;
    drive(1'b1, 4'b1001, 1'b1);
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b1101 || out_mode !== 1'b1) begin
      bad++;
      $display("FAIL mode1_a: got v=%b d=%b m=%b want 1 1101 1", out_valid, out_data, out_mode);
    end
    drive(1'b1, 4'b0111, 1'b1);
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b0100 || out_mode !== 1'b1) begin
      bad++;
      $display("FAIL mode1_b: got v=%b d=%b m=%b want 1 0100 1", out_valid, out_data, out_mode);
    end
    drive(1'b0, '0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] din  [3] = '{4'b0110, 4'b0101, 4'b1111};
    logic         dmode[3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] dexp [3] = '{4'b0100, 4'b0111, 4'b1010};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, din[k], dmode[k]);
      step();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== dexp[k] || out_mode !== dmode[k]) begin
        bad++;
        $display("FAIL b2b_%0d: got r=%b v=%b d=%b m=%b want 1 1 %b %b", k, in_ready, out_valid, out_data, out_mode, dexp[k], dmode[k]);
      end
    end
    drive(1'b0, '0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b0001 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_a: got v=%b d=%b r=%b want 1 0001 1", out_valid, out_data, in_ready);
    end
    drive(1'b1, 4'b0011, 1'b0);
    step();
    total++;
    if (in_ready !== 1'b0 || out_data !== 4'b0001) begin
      bad++;
      $display("FAIL bp_b_skid: got r=%b d=%b want 0 0001", in_ready, out_data);
    end
    drive(1'b1, 4'b0010, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'b0001 || out_mode !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: got r=%b v=%b d=%b m=%b want 0 1 0001 0", k, in_ready, out_valid, out_data, out_mode);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_data !== 4'b0010 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got d=%b r=%b want 0010 1", out_data, in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b0011) begin
      bad++;
      $display("FAIL bp_c: got v=%b d=%b want 1 0011", out_valid, out_data);
    end
    drive(1'b0, '0, 1'b0);
    step();
    total++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: got v=%b q=%0d want 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 4'b1010, 1'b1);
    step();
    drive(1'b1, 4'b0110, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: got v=%b d=%h r=%b want 0 0 1", out_valid, out_data, in_ready);
    end
    sb.delete();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'b0100, 1'b1);
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'b0110 || out_mode !== 1'b1) begin
      bad++;
      $display("FAIL rst_first: got v=%b d=%b m=%b want 1 0110 1", out_valid, out_data, out_mode);
    end
    drive(1'b0, '0, 1'b0);
    step();
  endtask

`ifdef GRAY_ADJ_CHECK_EN
  task automatic test_adj();
    logic [W-1:0] seq[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    rst = 1'b1;
    #1;
    sb.delete();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, seq[k], 1'b0);
      step();
      total++;
      if (adj_err !== 1'b0 || adj_err_sticky !== 1'b0) begin
        bad++;
        $display("FAIL adj_ok_%0d: got e=%b s=%b want 0 0", k, adj_err, adj_err_sticky);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'b0111, 1'b0);
      step();
      total++;
      if (adj_err !== 1'b1 || adj_err_sticky !== 1'b1) begin
        bad++;
        $display("FAIL adj_err_%0d: got e=%b s=%b want 1 1", k, adj_err, adj_err_sticky);
      end
      drive(1'b0, '0, 1'b0);
      step();
      total++;
      if (adj_err !== 1'b0 || adj_err_sticky !== 1'b1) begin
        bad++;
        $display("FAIL adj_pulse_%0d: got e=%b s=%b want 0 1", k, adj_err, adj_err_sticky);
      end
    end
  endtask
`endif

  task automatic test_random();
    int n;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_mode   = 1'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    total++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_drain: got q=%0d v=%b want 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef GRAY_ADJ_CHECK_EN
    test_adj();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_bin_conv_pipe.md
Name: gray_bin_conv_pipe

Overview:
Parametrised, registered Gray/binary converter with valid/ready handshakes on both sides. Each transfer carries a mode bit that selects Gray-to-binary or binary-to-Gray. A 2-entry output path (main register plus skid register) gives full throughput under backpressure with a registered in_ready. The block sits between Gray-coded pointer/counter sources (CDC paths, encoders) and binary arithmetic consumers, and supports the reverse direction as well.

Parameters:
WIDTH, 4, data width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept; registered
in_data  input  WIDTH  word to convert
in_mode  input  1  0 = Gray->binary, 1 = binary->Gray
out_valid  output  1  converted word valid
out_ready  input  1  consumer accepts
out_data  output  WIDTH  converted word
out_mode  output  1  mode the word was converted with

Behaviour:
- Accept on in_valid && in_ready. Transfer out on out_valid && out_ready.
- Conversion is combinational on in_data before storage.
  - Mode 0: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - Mode 1: g = b ^ (b >> 1).
- Latency: 1 cycle. A word accepted at edge N is presented at out_data after edge N, provided the main register is empty or draining.
- Storage: main register (drives out_*) and skid register.
  - Accept while main is empty, or main is full and out_ready=1: word goes to main.
  - Accept while main is full and out_ready=0: word goes to skid; in_ready = 0 from the next cycle.
  - Skid full and out_ready=1: skid moves to main; in_ready = 1 from the next cycle. No input is accepted in that cycle, because in_ready was 0.
- in_ready = ~skid_valid, registered.
- Order is preserved. No word is dropped or duplicated.
- out_data and out_mode stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain with main full and skid empty: the new word replaces main; skid stays empty.
- Reset values: out_valid=0, out_data=0, out_mode=0, in_ready=1, skid empty.
- Reset mid-operation discards both stored words immediately (asynchronous). The first accept is possible on the first edge after rst deasserts.
- in_data and in_mode are don't-care when in_valid=0.

Optional Feature:
Macro: GRAY_ADJ_CHECK_EN.
- Defined: adds two outputs.
  - adj_err (output, 1 bit): registered pulse.
  - adj_err_sticky (output, 1 bit): stays high until rst.
- Check rule:
  - The block keeps the last accepted mode-0 input word and a "have previous" flag. Both are cleared by reset.
  - On each mode-0 accept with the previous-word flag set, the new word is compared with the previous one.
  - If the Hamming distance is not 1 (including 0), adj_err is high for exactly one cycle after the accepting edge and adj_err_sticky sets.
  - Mode-1 accepts neither update nor check the history.
- Not defined: both ports and all check logic are absent. Datapath behaviour is identical either way.

Test Plan:
1. WIDTH=4, out_ready=1: mode 0 inputs 1101 then 1000 -> out_data 1001 then 1111, each 1 cycle after accept, out_mode=0.
2. Mode 1 inputs 1001 then 0111 -> out_data 1101 then 0100, out_mode=1. Back-to-back mixed modes 0,1,0 hold full throughput: in_ready stays 1 and out_valid stays high on consecutive cycles.
3. Backpressure: out_ready=0; offer A=0001, B=0011, C=0010 (mode 0) -> A held at output as 0001, B in skid, in_ready=0 the cycle after B's accept, C not accepted. Raise out_ready -> outputs 0001, 0010, 0011 in order; C accepted after in_ready returns to 1.
4. Assert rst while main and skid are full -> out_valid=0, out_data=0, in_ready=1 immediately. The next word after deassert appears 1 cycle after accept.
5. GRAY_ADJ_CHECK_EN: mode 0 sequence 0000, 0001, 0011, 0010 -> adj_err stays 0. Then 0111 (distance 2) -> adj_err pulses 1 cycle and adj_err_sticky=1. Then repeat 0111 (distance 0) -> pulse again.
6. Random mode/data with random in_valid and out_ready for 10k cycles, compared against a reference queue model -> zero mismatches, no drops, order kept.
